// File: rtl/fifo32_buffer.sv
// fifo32_buffer: 32-bit synchronous FIFO with occupancy and sticky error flags
module fifo32_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             res,
  input  logic [WIDTH-1:0] data_in,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count,
  output logic             overflow,
  output logic             underflow
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             rd_acc, wr_acc;
  assign full   = count == (PTR_W+1)'(DEPTH);
  assign empty  = count == '0;
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);
  // storage: a write into a full FIFO lands in the slot freed by the same-edge read
  always_ff @(posedge clk)
    if (wr_acc && !res) mem[wr_ptr] <= data_in;
  // pointers, occupancy, registered output and sticky error flags
  always_ff @(posedge clk or posedge res)
    if (res) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end
      count     <= (wr_acc && !rd_acc) ? count + 1'b1 : (!wr_acc && rd_acc) ? count - 1'b1 : count;
      overflow  <= overflow || (wr_en && !wr_acc);
      underflow <= underflow || (rd_en && !rd_acc);
    end
endmodule

// File: tb/tb_fifo32_buffer.sv
// tb_fifo32_buffer: randomized and directed checks of fifo32_buffer against a queue model
module tb_fifo32_buffer;
  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic [31:0] data_in = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] data_out;
  logic        full, empty, overflow, underflow;
  logic [2:0]  count;
  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];
  logic [31:0] m_dout;
  logic        m_ov, m_un;
  fifo32_buffer dut (
    .clk(clk), .res(res), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(data_out), .full(full), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_ov = 1'b0;
    m_un = 1'b0;
  endtask
  task automatic cycle(input logic w, input logic r, input logic [31:0] d);
    bit rd_ok, wr_ok;
    wr_en = w;
    rd_en = r;
    data_in = d;
    @(posedge clk);
    if (!res) begin
      rd_ok = r && q.size() > 0;
      wr_ok = w && (q.size() < 4 || rd_ok);
      if (rd_ok) m_dout = q.pop_front();
      if (wr_ok) q.push_back(d);
      m_ov = m_ov || (w && !wr_ok);
      m_un = m_un || (r && !rd_ok);
    end
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask
  task automatic test_reset();
    res = 1'b1;
    cycle(1'b1, 1'b1, 32'hFFFF_FFFF);
    cycle(1'b1, 1'b1, 32'hFFFF_FFFF);
    model_reset();
    checks++;
    if ({empty, full, count, data_out, overflow, underflow} !== {1'b1, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: e=%b f=%b c=%0d d=%h ov=%b un=%b required e=1 f=0 c=0 d=0 ov=0 un=0",
               empty, full, count, data_out, overflow, underflow);
    end
    res = 1'b0;
  endtask
  task automatic test_fill_drain();
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 1'b0, 32'(i));
      checks++;
      if (count !== 3'(i) || full !== (i == 4)) begin
        errors++;
        $display("FAIL fill[%0d]: count=%0d full=%b required count=%0d full=%b", i, count, full, i, i == 4);
      end
    end
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b0, 1'b1, 32'h0);
      checks++;
      if (data_out !== 32'(i)) begin
        errors++;
        $display("FAIL drain[%0d]: data_out=%h required %h", i, data_out, 32'(i));
      end
    end
    checks++;
    if (empty !== 1'b1 || count !== 3'd0) begin
      errors++;
      $display("FAIL drain_empty: empty=%b count=%0d required 1/0", empty, count);
    end
  endtask
  task automatic test_overflow();
    for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b0, 32'(i));
    cycle(1'b1, 1'b0, 32'hDEAD_BEEF);
    checks++;
    if (overflow !== 1'b1 || count !== 3'd4 || full !== 1'b1) begin
      errors++;
      $display("FAIL overflow: ov=%b count=%0d full=%b required 1/4/1", overflow, count, full);
    end
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b0, 1'b1, 32'h0);
      checks++;
      if (data_out !== 32'(i)) begin
        errors++;
        $display("FAIL overflow_read[%0d]: data_out=%h required %h", i, data_out, 32'(i));
      end
    end
  endtask
  task automatic test_underflow();
    cycle(1'b0, 1'b1, 32'h0);
    checks++;
    if (data_out !== 32'h4 || underflow !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL underflow: data_out=%h un=%b ov=%b required 00000004/1/1", data_out, underflow, overflow);
    end
    cycle(1'b1, 1'b1, 32'hA);
    checks++;
    if (count !== 3'd1 || data_out !== 32'h4 || empty !== 1'b0) begin
      errors++;
      $display("FAIL empty_both: count=%0d data_out=%h empty=%b required 1/00000004/0", count, data_out, empty);
    end
  endtask
  task automatic test_wrap();
    cycle(1'b1, 1'b0, 32'hB);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 32'h10 + 32'(i));
      checks++;
      if (count !== 3'd2 || full !== 1'b0 || empty !== 1'b0 ||
          data_out !== (i < 2 ? 32'hA + 32'(i) : 32'h10 + 32'(i - 2))) begin
        errors++;
        $display("FAIL wrap[%0d]: data_out=%h count=%0d full=%b empty=%b required %h/2/0/0", i, data_out,
                 count, full, empty, (i < 2 ? 32'hA + 32'(i) : 32'h10 + 32'(i - 2)));
      end
    end
  endtask
  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h70 + 32'(i));
    #2 res = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({empty, full, count, data_out, overflow, underflow} !== {1'b1, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: e=%b f=%b c=%0d d=%h ov=%b un=%b required 1/0/0/0/0/0",
               empty, full, count, data_out, overflow, underflow);
    end
    #2 res = 1'b0;
    cycle(1'b1, 1'b0, 32'h55);
    cycle(1'b0, 1'b1, 32'h0);
    checks++;
    if (data_out !== 32'h55 || empty !== 1'b1) begin
      errors++;
      $display("FAIL post_reset: data_out=%h empty=%b required 00000055/1", data_out, empty);
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom), 1'($urandom), $urandom);
      checks++;
      if (data_out !== m_dout || count !== 3'(q.size()) || full !== (q.size() == 4) ||
          empty !== (q.size() == 0) || overflow !== m_ov || underflow !== m_un) begin
        errors++;
        $display("FAIL random[%0d]: d=%h c=%0d f=%b e=%b ov=%b un=%b required d=%h c=%0d f=%b e=%b ov=%b un=%b",
                 i, data_out, count, full, empty, overflow, underflow,
                 m_dout, q.size(), q.size() == 4, q.size() == 0, m_ov, m_un);
      end
    end
  endtask
  initial begin
    model_reset();
    #2;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo32_buffer.md
Name: fifo32_buffer

Overview:
- Synchronous FIFO that buffers 32-bit data words upstream of the 32-bit register stage.
- Absorbs bursts from a producer and presents one word per accepted read.
- Its registered output drives the register stage's data input directly.
- Also reports occupancy and sticky overflow/underflow error flags.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 4, number of storage entries; must be a power of 2, at least 2.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- res  input  1  asynchronous reset, active-high; clears all state immediately.
- data_in  input  WIDTH  word to write.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- data_out  output  WIDTH  registered word from the most recent accepted read.
- full  output  1  high when count == DEPTH.
- empty  output  1  high when count == 0.
- count  output  PTR_W+1  number of stored words, range 0..DEPTH.
- overflow  output  1  sticky; set by a write attempted while full.
- underflow  output  1  sticky; set by a read attempted while empty.

Behaviour:
- Reset (res=1, asynchronous): the following clear at once, with no clock edge needed:
  - wr_ptr=0, rd_ptr=0, count=0
  - data_out=0, overflow=0, underflow=0
  - full=0, empty=1
  - Storage contents are don't-care.
  - While res is high, clock edges have no effect.
- Write accepted: wr_en && !full at a rising edge.
  - mem[wr_ptr] <= data_in
  - wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- Read accepted: rd_en && !empty at a rising edge.
  - data_out <= mem[rd_ptr]
  - rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
  - Read latency is 1 clock: data_out is valid after the edge that accepts the read.
- data_out holds its value on every edge without an accepted read.
- count update:
  - +1 on write-only.
  - -1 on read-only.
  - Unchanged when both are accepted or when neither is.
- full and empty are decoded combinationally from count. They have no lag relative to count.
- Full, both wr_en and rd_en asserted: both are accepted and count stays DEPTH. The read returns the oldest word, and the new word goes into the slot just freed.
- Empty, both asserted: only the write is accepted, with count 0->1. The read is rejected, data_out holds, and underflow is set.
- Write while full (and no accepted read): data_in is dropped, and storage and pointers are unchanged. overflow <= 1.
- Read while empty: data_out and pointers are unchanged. underflow <= 1.
- overflow and underflow stay set until res is asserted.
- Ordering is strict FIFO, with no word loss or duplication across pointer wrap-around.
- Reset asserted mid-burst: everything stored is discarded. After release, the first accepted write/read pair returns the new word.
- A single-port-write, single-port-read storage array is sufficient. No combinational path exists from inputs to data_out.

Test Plan:
1. Reset with res=1 and wr_en=rd_en=1 for 2 edges → empty=1, full=0, count=0, data_out=0, overflow=0, underflow=0.
2. Write 0x00000001, 0x00000002, 0x00000003, 0x00000004 on consecutive edges → count steps 1,2,3,4 and full=1 after the 4th edge. Then 4 reads → data_out is 1,2,3,4, each one edge after its read; empty=1 at the end.
3. Full FIFO, write 0xDEADBEEF with rd_en=0 → overflow=1, count=4, and the next 4 reads return the original 4 words (0xDEADBEEF never appears).
4. Empty FIFO, rd_en=1 with data_out=0x00000004 → data_out stays 0x00000004 and underflow=1. Then simultaneous wr_en=1 (0x0000000A) and rd_en=1 on empty → count=1 and data_out unchanged.
5. Wrap-around, at steady occupancy of 2:
   - Stimulus: 20 cycles of simultaneous wr_en and rd_en, writing an incrementing pattern 0x10..0x23.
   - Response: data_out shows 0x10..0x21 in order, count stays 2, and full/empty never assert.
6. Write 3 words, assert res for 3ns between clock edges → outputs clear immediately without an edge. After release, write 0x55 then read → data_out=0x55.
